// File: rtl/uart_tx_param.sv
// UART transmitter with a small transmit FIFO; configurable framing.
// Ports: clk, rst_n (async, active-high), s_data/s_valid/s_ready in, o_tx/busy/tx_done/fifo_count/debug_frame out.
module uart_tx_param #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          o_tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DATA_BITS-1:0]          debug_frame
);

  localparam int CPB      = CLK_FREQ_HZ / BAUD_RATE;
  localparam int STOP_LEN = STOP_BITS * CPB;
  localparam int BW       = $clog2(STOP_LEN + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int NW       = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic [2:0]           state;
  logic [BW-1:0]        baud_cnt;
  logic [NW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic push;
  logic pop;
  logic have;
  logic bit_end;
  logic stop_end;
  logic par_bit;

  assign s_ready    = count < CW'(FIFO_DEPTH);
  assign fifo_count = count;
  assign push       = s_valid && s_ready;
  assign have       = count != '0;
  assign bit_end    = baud_cnt == BW'(CPB - 1);
  assign stop_end   = baud_cnt == BW'(STOP_LEN - 1);

  // A pop happens when idle, or back-to-back at the end of a frame.
  assign pop = have &&
    ((state == ST_IDLE) ||
     (state == ST_STOP && stop_end));

  assign busy    = state != ST_IDLE;
  assign tx_done = (state == ST_STOP) && stop_end;

  // Odd parity is the inverse of the even parity bit.
  assign par_bit = (^debug_frame) ^ (PARITY == 2);

  always_ff @(posedge clk) begin
    if (!rst_n && push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= ST_IDLE;
      o_tx        <= 1'b1;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      debug_frame <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (have) begin
            shreg       <= mem[rd_ptr];
            debug_frame <= mem[rd_ptr];
            o_tx        <= 1'b0;
            baud_cnt    <= '0;
            state       <= ST_START;
          end
        end
        (state == ST_START): begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            o_tx     <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        (state == ST_DATA): begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == NW'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                o_tx  <= par_bit;
                state <= ST_PAR;
              end else begin
                o_tx  <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        (state == ST_PAR): begin
          if (bit_end) begin
            baud_cnt <= '0;
            o_tx     <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        (state == ST_STOP): begin
          if (stop_end) begin
            baud_cnt <= '0;
            if (have) begin
              shreg       <= mem[rd_ptr];
              debug_frame <= mem[rd_ptr];
              o_tx        <= 1'b0;
              state       <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four framings, scoreboard of expected words.
// A negedge monitor decodes every o_tx sample against the queued word.
module tb_uart_tx_param;

  localparam int CPB = 234;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 1, 2, 2};
  localparam int SB [4] = '{1, 1, 1, 2};

  typedef struct packed {
    logic [8:0] w;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst [4];
  logic [8:0] sd  [4];
  logic       sv  [4];
  logic       sr  [4];
  logic       tx  [4];
  logic       bz  [4];
  logic       dn  [4];
  logic [2:0] fc  [4];
  logic [7:0] dbg0, dbg1, dbg2;
  logic [6:0] dbg3;

  exp_t q [4][$];
  int   act [4];
  int   t   [4];
  int   dcnt[4];
  int   gap [4];
  logic contig[4];
  logic err [4];
  logic [1:0] errv[4];
  exp_t cur [4];

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_param u0 (
    .clk(clk), .rst_n(rst[0]),
    .s_data(sd[0][7:0]), .s_valid(sv[0]),
    .s_ready(sr[0]), .o_tx(tx[0]),
    .busy(bz[0]), .tx_done(dn[0]),
    .fifo_count(fc[0]), .debug_frame(dbg0)
  );

  uart_tx_param #(.PARITY(1)) u1 (
    .clk(clk), .rst_n(rst[1]),
    .s_data(sd[1][7:0]), .s_valid(sv[1]),
    .s_ready(sr[1]), .o_tx(tx[1]),
    .busy(bz[1]), .tx_done(dn[1]),
    .fifo_count(fc[1]), .debug_frame(dbg1)
  );

  uart_tx_param #(.PARITY(2)) u2 (
    .clk(clk), .rst_n(rst[2]),
    .s_data(sd[2][7:0]), .s_valid(sv[2]),
    .s_ready(sr[2]), .o_tx(tx[2]),
    .busy(bz[2]), .tx_done(dn[2]),
    .fifo_count(fc[2]), .debug_frame(dbg2)
  );

  uart_tx_param #(
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst_n(rst[3]),
    .s_data(sd[3][6:0]), .s_valid(sv[3]),
    .s_ready(sr[3]), .o_tx(tx[3]),
    .busy(bz[3]), .tx_done(dn[3]),
    .fifo_count(fc[3]), .debug_frame(dbg3)
  );

  function automatic logic [8:0] get_dbg(input int i);
    case (i)
      0: return {1'b0, dbg0};
      1: return {1'b0, dbg1};
      2: return {1'b0, dbg2};
      default: return {2'b0, dbg3};
    endcase
  endfunction

  function automatic int flen(input int i);
    return (1 + DB[i] + (PM[i] != 0 ? 1 : 0) + SB[i]) * CPB;
  endfunction

  function automatic logic lvl(input int i, input int tt);
    int   b;
    exp_t e;
    b = tt / CPB;
    e = cur[i];
    if (b == 0) return 1'b0;
    if (b <= DB[i]) return e.w[b-1];
    if (PM[i] != 0 && b == DB[i] + 1) return e.p;
    return 1'b1;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic lv;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rst[i]) begin
          act[i] = 0;
          q[i].delete();
          gap[i] = 0;
          contig[i] = 1'b0;
        end else begin
          if (act[i] == 0 && tx[i] == 1'b0) begin
            act[i]  = 1;
            t[i]    = 0;
            dcnt[i] = 0;
            err[i]  = 1'b0;
            if (q[i].size() == 0) begin
              cur[i] = '0;
              check($sformatf("dut%0d_unexpected_frame", i), 1, 0);
            end else begin
              cur[i] = q[i].pop_front();
              check($sformatf("dut%0d_debug_frame", i),
                    32'(get_dbg(i)), 32'(cur[i].w));
            end
            if (contig[i])
              check($sformatf("dut%0d_gap", i), gap[i], 0);
            contig[i] = 1'b0;
          end else if (act[i] == 0) begin
            gap[i]++;
          end
          if (act[i] != 0) begin
            lv = lvl(i, t[i]);
            if (!err[i] && (tx[i] !== lv || bz[i] !== 1'b1)) begin
              err[i]  = 1'b1;
              errv[i] = {bz[i], tx[i]};
            end
            if (dn[i]) dcnt[i]++;
            if (t[i] % CPB == CPB - 1) begin
              check($sformatf("dut%0d_w%0h_bit%0d_busy_tx",
                              i, cur[i].w, t[i] / CPB),
                    err[i] ? 32'(errv[i]) : 32'({1'b1, lv}),
                    32'({1'b1, lv}));
              err[i] = 1'b0;
            end
            t[i]++;
            if (t[i] == flen(i)) begin
              act[i] = 0;
              check($sformatf("dut%0d_tx_done_count", i), dcnt[i], 1);
              contig[i] = q[i].size() > 0;
              gap[i] = 0;
            end
          end
        end
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic push(input int i, input logic [8:0] d,
                      input logic p, input logic acc,
                      input logic hold);
    exp_t e;
    sd[i] = d;
    sv[i] = 1'b1;
    check($sformatf("dut%0d_s_ready_w%0h", i, d), sr[i], acc);
    if (acc) begin
      e.w = d;
      e.p = p;
      q[i].push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) sv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while (!(q[i].size() == 0 && act[i] == 0 && !bz[i])
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("dut%0d_idle_timeout", i), n < budget, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      sv[i]  = 1'b0;
      sd[i]  = '0;
      act[i] = 0;
      gap[i] = 0;
      contig[i] = 1'b0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut%0d_rst_tx", i), tx[i], 1);
      check($sformatf("dut%0d_rst_busy", i), bz[i], 0);
      check($sformatf("dut%0d_rst_done", i), dn[i], 0);
      check($sformatf("dut%0d_rst_count", i), fc[i], 0);
      check($sformatf("dut%0d_rst_dbg", i), get_dbg(i), 0);
    end
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(posedge clk);
    #1;

    // 0x5A: four ones -> even parity 0, odd parity 1.
    // 0x7F in 7 bits: seven ones -> odd parity 0.
    push(1, 9'h5A, 1'b0, 1'b1, 1'b0);
    push(2, 9'h5A, 1'b1, 1'b1, 1'b0);
    push(3, 9'h7F, 1'b0, 1'b1, 1'b0);
    push(0, 9'h5A, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) wait_idle(i, 6000);
    check("dut0_dbg_after_5a", get_dbg(0), 9'h5A);

    // Six back-to-back pushes into a depth-4 FIFO.
    for (int k = 1; k <= 6; k++)
      push(0, 9'(k), 1'b0, k <= 5, 1'b1);
    check("dut0_count_full", fc[0], 4);
    sv[0] = 1'b0;
    wait_idle(0, 15000);

    // Reset in the middle of data bit 3 of 0xAA.
    push(0, 9'hAA, 1'b0, 1'b1, 1'b1);
    push(0, 9'h55, 1'b0, 1'b1, 1'b0);
    repeat (4 * CPB + CPB / 2) @(posedge clk);
    #3;
    check("dut0_pre_rst_busy", bz[0], 1);
    rst[0] = 1'b1;
    #1;
    check("dut0_midrst_tx", tx[0], 1);
    check("dut0_midrst_busy", bz[0], 0);
    check("dut0_midrst_count", fc[0], 0);
    check("dut0_midrst_dbg", get_dbg(0), 0);
    @(posedge clk);
    #1;
    sd[0] = 9'h33;
    sv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sv[0] = 1'b0;
    check("dut0_rst_push_count", fc[0], 0);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    check("dut0_post_rst_ready", sr[0], 1);
    check("dut0_post_rst_count", fc[0], 0);
    repeat (3000) @(posedge clk);
    #1;
    check("dut0_no_55_tx", tx[0], 1);
    check("dut0_no_55_busy", bz[0], 0);

    // All-zero then all-one words, s_valid held.
    push(0, 9'h00, 1'b0, 1'b1, 1'b1);
    check("dut0_idle_at_push_edge", tx[0], 1);
    push(0, 9'hFF, 1'b0, 1'b1, 1'b0);
    check("dut0_start_next_edge", tx[0], 0);
    wait_idle(0, 6000);
    check("dut0_final_dbg", get_dbg(0), 9'hFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
